cache_miss_handler: RTL

- Consumes the data-cache response bundle (hit, data, addr) and either forwards a hit to the load writeback path or runs a line refill on a miss.
- Sits directly downstream of the cache lookup stage and between it and the memory port.
- Drives the pipeline stall, fetches the full line from memory beat by beat, writes it back into the cache array, and returns the missing (critical) word.

---
 rtl/cache_miss_handler_pkg.sv | 45 ++++
 rtl/cache_miss_handler_refill_buffer.sv | 63 ++++++
 rtl/cache_miss_handler.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cache_miss_handler_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache miss handler:
//   - refill FSM state encoding (IDLE, REQ, WAIT, FILL)
//   - word/address geometry derived from the word width and default line size
//   - line-address mask helper
// WORD_WIDTH and PHYSICAL_ADDR_WIDTH normally come from CPU_define.vh. The
// fallbacks below give the standard 32-bit configuration when that header has
// not been included first.
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif

package cache_pkg;

    localparam int WORD_W         = `WORD_WIDTH;
    localparam int PADDR_W        = `PHYSICAL_ADDR_WIDTH;
    localparam int DEF_LINE_WORDS = 4;
    // Byte-offset bits inside one word.
    localparam int BOFF           = $clog2(WORD_W / 8);
    // Word-index bits inside one line of the default size.
    localparam int IDX            = $clog2(DEF_LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } state_e;

    // Clear the byte-offset and word-index bits to get the line base address.
    function automatic logic [PADDR_W-1:0] line_addr(
        input logic [PADDR_W-1:0] addr,
        input int                 idx_bits
    );
        logic [PADDR_W-1:0] mask;
        mask = {PADDR_W{1'b1}} << (BOFF + idx_bits);
        return addr & mask;
    endfunction

endpackage : cache_pkg

// File: rtl/cache_miss_handler_refill_buffer.sv
// -----------------------------------------------------------------------------
// refill_buffer
// Beat counter plus a LINE_WORDS x WORD_W register array that assembles a
// cache line from memory beats arriving in ascending word order.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   clear_i        reset the beat counter (start of a new refill)
//   we_i           write data_i into slot [counter] and advance the counter
//   data_i         beat data
//   sel_i          word index for word_o
//   last_o         counter points at the final slot of the line
//   line_o         assembled line, word 0 in the LSBs
//   word_o         word selected by sel_i
// -----------------------------------------------------------------------------
module refill_buffer #(
    parameter int LINE_WORDS = 4,
    parameter int WORD_W     = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear_i,
    input  logic                           we_i,
    input  logic [WORD_W-1:0]              data_i,
    input  logic [$clog2(LINE_WORDS)-1:0]  sel_i,
    output logic                           last_o,
    output logic [LINE_WORDS*WORD_W-1:0]   line_o,
    output logic [WORD_W-1:0]              word_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);

    logic [IDX_W-1:0]  cnt_q;
    logic [WORD_W-1:0] mem_q [LINE_WORDS];

    // Beat counter and line storage update.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (we_i) begin
            mem_q[cnt_q] <= data_i;
            // Wraps to 0 after the last beat; the next refill clears it anyway.
            cnt_q        <= cnt_q + 1'b1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Flatten the storage into the line bus and pick the requested word.
    always_comb begin
        line_o = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_o[i*WORD_W +: WORD_W] = mem_q[i];
        end
        word_o = mem_q[sel_i];
        last_o = (cnt_q == IDX_W'(LINE_WORDS - 1));
    end

endmodule : refill_buffer

// File: rtl/cache_miss_handler.sv
// -----------------------------------------------------------------------------
// cache_miss_handler
// Sits after the data-cache lookup. Hits are returned to the load writeback
// path one cycle later. Misses stall the pipeline, issue a line read to
// memory, collect LINE_WORDS beats, write the line back into the cache
// (fill_*) and return the critical word on load_*.
// Optional build macro: CACHE_MISS_PERF_EN adds a 32-bit saturating miss
// counter on output miss_count.
// Ports:
//   clock, reset                         clock, synchronous active-high reset
//   resp_valid/hit/data/addr             cache lookup response
//   mem_req_valid/ready/addr             line-read request to memory
//   mem_resp_valid/data                  refill beats, ascending word order
//   fill_valid/addr/data                 line write into the cache array
//   stall                                hold the upstream pipeline
//   load_valid/data                      returned load word
//   miss_count (CACHE_MISS_PERF_EN only) number of misses seen
// -----------------------------------------------------------------------------
module cache_miss_handler
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          resp_valid,
    input  logic                          resp_hit,
    input  logic [WORD_W-1:0]             resp_data,
    input  logic [PADDR_W-1:0]            resp_addr,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [PADDR_W-1:0]            mem_req_addr,
    input  logic                          mem_resp_valid,
    input  logic [WORD_W-1:0]             mem_resp_data,
    output logic                          fill_valid,
    output logic [PADDR_W-1:0]            fill_addr,
    output logic [LINE_WORDS*WORD_W-1:0]  fill_data,
    output logic                          stall,
    output logic                          load_valid,
    output logic [WORD_W-1:0]             load_data
`ifdef CACHE_MISS_PERF_EN
    ,
    output logic [31:0]                   miss_count
`endif
);

    localparam int LW_IDX = $clog2(LINE_WORDS);

    state_e                      state_q, state_d;
    logic [PADDR_W-1:0]          line_addr_q, line_addr_d;
    logic [LW_IDX-1:0]           word_idx_q, word_idx_d;
    logic                        load_valid_q, load_valid_d;
    logic [WORD_W-1:0]           load_data_q, load_data_d;

    logic                        miss_s;
    logic                        buf_clear_s;
    logic                        buf_we_s;
    logic                        buf_last_s;
    logic [LINE_WORDS*WORD_W-1:0] buf_line_s;
    logic [WORD_W-1:0]           buf_word_s;

    refill_buffer #(
        .LINE_WORDS (LINE_WORDS),
        .WORD_W     (WORD_W)
    ) u_refill_buffer (
        .clock   (clock),
        .reset   (reset),
        .clear_i (buf_clear_s),
        .we_i    (buf_we_s),
        .data_i  (mem_resp_data),
        .sel_i   (word_idx_q),
        .last_o  (buf_last_s),
        .line_o  (buf_line_s),
        .word_o  (buf_word_s)
    );

    // State and captured-miss registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            line_addr_q  <= '0;
            word_idx_q   <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            line_addr_q  <= line_addr_d;
            word_idx_q   <= word_idx_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
        end
    end

    // Next-state logic; resp_* is only looked at in IDLE and beats only in WAIT.
    always_comb begin
        state_d      = state_q;
        line_addr_d  = line_addr_q;
        word_idx_d   = word_idx_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        miss_s       = 1'b0;
        buf_clear_s  = 1'b0;
        buf_we_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (resp_valid && resp_hit) begin
                    load_valid_d = 1'b1;
                    load_data_d  = resp_data;
                    state_d      = IDLE;
                end else if (resp_valid) begin
                    miss_s      = 1'b1;
                    line_addr_d = line_addr(resp_addr, LW_IDX);
                    word_idx_d  = resp_addr[BOFF +: LW_IDX];
                    state_d     = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    buf_clear_s = 1'b1;
                    state_d     = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    buf_we_s = 1'b1;
                    if (buf_last_s) begin
                        state_d = FILL;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            FILL: begin
                // Keep the critical word on load_data after the pulse.
                load_data_d = buf_word_s;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; everything except the miss-cycle stall comes from registers.
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        fill_valid    = 1'b0;
        fill_addr     = '0;
        fill_data     = '0;
        load_valid    = load_valid_q;
        load_data     = load_data_q;
        stall         = (state_q != IDLE) || miss_s;
        case (state_q)
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_addr_q;
            end
            FILL: begin
                fill_valid = 1'b1;
                fill_addr  = line_addr_q;
                fill_data  = buf_line_s;
                load_valid = 1'b1;
                load_data  = buf_word_s;
            end
            default: begin
                mem_req_valid = 1'b0;
            end
        endcase
    end

`ifdef CACHE_MISS_PERF_EN
    logic [31:0] miss_count_q;

    // Saturating miss counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            miss_count_q <= 32'd0;
        end else if (miss_s && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_q <= miss_count_q + 32'd1;
        end else begin
            miss_count_q <= miss_count_q;
        end
    end

    assign miss_count = miss_count_q;
`endif

endmodule : cache_miss_handler
